// File: rtl/rr_decode_arbiter_if.sv
// ----------------------------------------------------------------
// rr_decode_arbiter_if: request/grant bundle between agents and arbiter
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface rr_decode_arbiter_if;
  logic        en;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        tmo;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_vld, tmo
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_vld, tmo
  );
endinterface

`default_nettype wire

// File: rtl/rr_decode_arbiter.sv
// ----------------------------------------------------------------
// rr_decode_arbiter: 16-way round-robin arbiter, index + one-hot grant
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module rr_decode_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rr_decode_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam bit         TMO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  gnt_idx_q, gnt_idx_d;
  logic        gnt_vld_q, gnt_vld_d;
  logic [15:0] gnt_q, gnt_d;
  logic        tmo_q, tmo_d;

  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  cand;

  logic        rel_done;
  logic        rel_wd;
  logic        rel_tmo;

  // Scan requests starting at the pointer, wrapping 15 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rel_done = bus.done;
  assign rel_wd   = !bus.req[gnt_idx_q];
  assign rel_tmo  = TMO_EN && (cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    tmo_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en && win_found) begin
          gnt_idx_d = win_idx;
          gnt_vld_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (rel_done || rel_wd || rel_tmo) begin
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q + 4'd1;
          state_d   = ST_RELEASE;
          // tmo flags only releases forced purely by the grant-length limit
          tmo_d     = rel_tmo && !rel_done && !rel_wd;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        gnt_vld_d = 1'b0;
      end
    endcase

    gnt_d = gnt_vld_d ? (16'h0001 << gnt_idx_d) : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 4'd0;
      cnt_q     <= 8'd0;
      gnt_idx_q <= 4'd0;
      gnt_vld_q <= 1'b0;
      gnt_q     <= 16'h0000;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_q     <= gnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.tmo     = tmo_q;

endmodule

`default_nettype wire
